// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid/frame_err pulses.
// Optional 8E1 framing with parity checking when UART_RX_PARITY_EN is defined.
module uart_rx_module #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_meta_q, rx_s_q, rx_prev_q;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad_q, parity_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Re-arm only on a real 1->0 edge so a stuck-low line cannot retrigger.
        if (rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d        = '0;
          parity_bad_d = (^shift_q) ^ rx_s_q;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (parity_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else begin
            valid_d    = 1'b1;
            data_out_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module at 16 clocks per bit; a negedge monitor logs output pulses.
module tb_uart_rx_module;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_cmp;
  int n_fail;

  int         cyc;
  int         n_valid, n_ferr, n_perr, n_viol;
  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  logic       busy_seen;
  logic       busy_after_valid;
  logic       prev_pulse, prev_valid;

  uart_rx_module #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid++;
      vq_data.push_back(data_out);
      vq_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) n_ferr++;
    if (parity_err === 1'b1) n_perr++;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) n_viol++;
    if (prev_pulse && (valid || frame_err || parity_err)) n_viol++;
    if (prev_valid) busy_after_valid = busy;
    prev_pulse = valid || frame_err || parity_err;
    prev_valid = valid;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) rx = 1'b1;
`endif
    send_bit(stop_b);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_out); end
    if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", parity_err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    int v0, f0, idx, start_cyc, lat;
    logic [7:0] got;
    v0 = n_valid; f0 = n_ferr; idx = vq_data.size();
    busy_seen = 1'b0;
    busy_after_valid = 1'b1;
    start_cyc = cyc + 1;
    send_frame(8'h55, 1'b1, 1'b1);
    send_bit(1'b1);
    got = (vq_data.size() > idx) ? vq_data[idx] : 8'hxx;
    lat = (vq_cyc.size() > idx) ? vq_cyc[idx] - start_cyc : -1;
    n_cmp += 6;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL single_valid_cnt got %0d want 1", n_valid - v0); end
    if (got !== 8'h55) begin n_fail++; $display("FAIL single_data got %h want 55", got); end
    if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL single_ferr got %0d want 0", n_ferr - f0); end
    if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL single_busy_seen got %b want 1", busy_seen); end
    if (busy_after_valid !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", busy_after_valid); end
    if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL single_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    int v0, idx, gap;
    logic [7:0] g0, g1;
    v0 = n_valid; idx = vq_data.size();
    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1);
    send_bit(1'b1);
    g0  = (vq_data.size() > idx) ? vq_data[idx] : 8'hxx;
    g1  = (vq_data.size() > idx + 1) ? vq_data[idx + 1] : 8'hxx;
    gap = (vq_cyc.size() > idx + 1) ? vq_cyc[idx + 1] - vq_cyc[idx] : -1;
`ifdef UART_RX_PARITY_EN
    gap = gap - CPB;
`endif
    n_cmp += 4;
    if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_cnt got %0d want 2", n_valid - v0); end
    if (g0 !== 8'hA3) begin n_fail++; $display("FAIL b2b_data0 got %h want a3", g0); end
    if (g1 !== 8'h0F) begin n_fail++; $display("FAIL b2b_data1 got %h want 0f", g1); end
    if (gap < 10 * CPB - 1 || gap > 10 * CPB + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", gap, 10 * CPB); end
  endtask

  task automatic test_glitch;
    int v0, f0, idx;
    logic [7:0] got;
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy); end
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", n_valid - v0); end
    if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - f0); end
    idx = vq_data.size();
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1);
    got = (vq_data.size() > idx) ? vq_data[idx] : 8'hxx;
    n_cmp += 1;
    if (got !== 8'h3C) begin n_fail++; $display("FAIL glitch_next_data got %h want 3c", got); end
  endtask

  task automatic test_break;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hFF, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (50 * CPB) @(negedge clk);
    n_cmp += 3;
    if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL break_ferr_cnt got %0d want 1", n_ferr - f0); end
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL break_valid got %0d want 0", n_valid - v0); end
    if (data_out !== 8'h3C) begin n_fail++; $display("FAIL break_data got %h want 3c", data_out); end
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic test_reset_mid;
    int v0, f0, idx;
    logic [7:0] got;
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx  = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", data_out); end
    rst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    idx = vq_data.size();
    send_frame(8'hC6, 1'b0, 1'b1);
    send_bit(1'b1);
    got = (vq_data.size() > idx) ? vq_data[idx] : 8'hxx;
    n_cmp += 3;
    if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL rstmid_valid_cnt got %0d want 1", n_valid - v0); end
    if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL rstmid_ferr got %0d want 0", n_ferr - f0); end
    if (got !== 8'hC6) begin n_fail++; $display("FAIL rstmid_data_after got %h want c6", got); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0, idx;
    logic [7:0] got;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    n_cmp += 3;
    if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL par_bad_perr got %0d want 1", n_perr - p0); end
    if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL par_bad_valid got %0d want 0", n_valid - v0); end
    if (data_out !== 8'hC6) begin n_fail++; $display("FAIL par_bad_data got %h want c6", data_out); end
    idx = vq_data.size();
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    got = (vq_data.size() > idx) ? vq_data[idx] : 8'hxx;
    n_cmp += 2;
    if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL par_good_perr got %0d want 1", n_perr - p0); end
    if (got !== 8'h07) begin n_fail++; $display("FAIL par_good_data got %h want 07", got); end
  endtask
`else
  task automatic test_parity;
    n_cmp += 1;
    if (n_perr !== 0) begin n_fail++; $display("FAIL parity_tied got %0d want 0", n_perr); end
  endtask
`endif

  task automatic test_exclusive;
    n_cmp += 1;
    if (n_viol !== 0) begin n_fail++; $display("FAIL pulse_exclusive got %0d violations want 0", n_viol); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    cyc = 0; n_valid = 0; n_ferr = 0; n_perr = 0; n_viol = 0;
    busy_seen = 1'b0; busy_after_valid = 1'b0;
    prev_pulse = 1'b0; prev_valid = 1'b0;
    rst = 1'b0;
    rx  = 1'b1;
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_reset_mid;
    test_parity;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
